// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling and a small first-word fall-through FIFO.
// Bytes with a bad stop bit raise frame_err; bytes arriving while the FIFO is full raise overrun.
module uart_rx_fifo #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 163,
    parameter int DVSR_BIT = 8,
    parameter int FIFO_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int DEPTH = 2 ** FIFO_W;
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Stop phases longer than one bit need more than 4 bits of sample count
    localparam int S_W   = (SB_TICK > 16) ? 5 : 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                r_sync1, r_sync2;
    logic [DVSR_BIT-1:0] r_tick_cnt;
    logic                w_tick;

    state_t              r_state, w_state_next;
    logic [S_W-1:0]      r_s, w_s_next;
    logic [N_W-1:0]      r_n, w_n_next;
    logic [DBIT-1:0]     r_b, w_b_next;
    logic                w_push, w_ferr;

    logic [DBIT-1:0]     r_mem [DEPTH];
    logic [FIFO_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic                r_full, r_empty;
    logic                w_wr_en, w_rd_en, w_ovr;
    logic                r_frame_err, r_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_push       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_state_next = START;
                    w_s_next     = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == S_W'(7)) begin
                        // A start bit that is high again at its midpoint was a glitch
                        if (!r_sync2) begin
                            w_state_next = DATA;
                            w_s_next     = '0;
                            w_n_next     = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == S_W'(15)) begin
                        w_b_next = {r_sync2, r_b[DBIT-1:1]};
                        w_s_next = '0;
                        if (r_n == N_W'(DBIT - 1))
                            w_state_next = STOP;
                        else
                            w_n_next = r_n + 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == S_W'(SB_TICK - 1)) begin
                        w_state_next = IDLE;
                        w_push       = r_sync2;
                        w_ferr       = !r_sync2;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_rd_en = rd_uart && !r_empty;
    assign w_wr_en = w_push && (!r_full || rd_uart);
    assign w_ovr   = w_push && r_full && !rd_uart;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (reset)
                    r_mem[gi] <= '0;
                else if (w_wr_en && (r_wr_ptr == FIFO_W'(gi)))
                    r_mem[gi] <= r_b;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b01: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_full   <= 1'b0;
                    r_empty  <= (FIFO_W'(r_rd_ptr + 1'b1) == r_wr_ptr);
                end
                2'b10: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_empty  <= 1'b0;
                    r_full   <= (FIFO_W'(r_wr_ptr + 1'b1) == r_rd_ptr);
                end
                2'b11: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_ovr;
        end
    end

    assign r_data    = r_mem[r_rd_ptr];
    assign rx_empty  = r_empty;
    assign rx_full   = r_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: oversampling ticks for stop bit (16/24/32 = 1/1.5/2 bits).
REQ-003 SHALL have parameter DVSR, default 163: clocks per oversampling tick (100 MHz / (16 * baud)).
REQ-004 SHALL have parameter DVSR_BIT, default 8: width of the tick counter.
REQ-005 SHALL have parameter FIFO_W, default 2: FIFO address bits, depth 2^FIFO_W.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port rd_uart, input, 1: pop request for the FIFO head.
REQ-010 SHALL have port r_data, output, DBIT: FIFO head, first-word fall-through.
REQ-011 SHALL have port rx_empty, output, 1: FIFO holds no bytes.
REQ-012 SHALL have port rx_full, output, 1: FIFO holds 2^FIFO_W bytes.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer; the FSM SHALL only see the synchronized value.
REQ-016 SHALL run a free-running tick counter 0..DVSR-1 and assert tick for one cycle when count = DVSR-1, then wrap to 0.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP, with sample counter s (4 bits) and bit counter n.
REQ-018 In IDLE, synchronized rx = 0 SHALL cause a move to START with s = 0.
REQ-019 In START, s SHALL increment on each tick; at s = 7 with tick:
- rx = 0 -> DATA, s = 0, n = 0.
- rx = 1 -> IDLE, treated as a glitch; no flags asserted.
REQ-020 In DATA, s SHALL increment on each tick; at s = 15 with tick:
- shift register b <= {rx, b[DBIT-1:1]} (LSB first), s = 0.
- n = DBIT-1 -> STOP; otherwise n increments.
REQ-021 In STOP, s SHALL increment on each tick; at s = SB_TICK-1 with tick, SHALL return to IDLE and:
- rx = 1 -> push b into the FIFO.
- rx = 0 -> pulse frame_err for one cycle and do not push.
REQ-022 The push SHALL occur on the same edge as the stop-bit sample; rx_empty SHALL read 0 from the next cycle.
REQ-023 FIFO full at push time with no simultaneous pop -> byte dropped, overrun pulses one cycle, FIFO contents unchanged.
REQ-024 Push and pop in the same cycle while full -> both performed, no overrun, rx_full stays 1.
REQ-025 Push and pop in the same cycle while empty -> push performed, pop ignored.
REQ-026 Pop while empty SHALL be ignored, with no pointer change.
REQ-027 Pop while not empty SHALL advance the read pointer; r_data SHALL show the next entry on the following cycle.
REQ-028 Read and write pointers SHALL wrap modulo 2^FIFO_W; full/empty SHALL be tracked explicitly (registered flags), not by pointer equality alone.
REQ-029 The FSM SHALL continue receiving while the FIFO is full; only the push is suppressed.

Reset
REQ-030 On reset, the following SHALL apply at the next edge:
- FSM = IDLE; s, n, b = 0.
- Synchronizer flops = 1; tick counter = 0.
- FIFO pointers = 0 and storage = 0.
REQ-031 Output values after reset SHALL be r_data = 0, rx_empty = 1, rx_full = 0, frame_err = 0, overrun = 0.
REQ-032 Reset mid-frame SHALL abandon the partial byte with no push and no flag.

Verification (DVSR = 4, bit = 64 clk)
REQ-033 Frame 0x55 with a valid stop bit -> rx_empty falls, r_data = 0x55, frame_err stays 0; rd_uart pulse -> rx_empty = 1.
REQ-034 Back-to-back frames 0xA3, 0x0F, no reads -> r_data = 0xA3; after pop r_data = 0x0F; after second pop rx_empty = 1.
REQ-035 Frame 0xFF with stop bit = 0 -> frame_err high for exactly 1 cycle, rx_empty stays 1, next valid frame 0x3C received correctly.
REQ-036 Low glitch of 24 clk on an idle line -> no push, no flags, FSM back in IDLE before the next frame.
REQ-037 FIFO_W = 2, frames 0x01..0x05 with no reads -> rx_full after the 4th, overrun pulses at the 5th stop sample; pops return 0x01..0x04.
REQ-038 Reset asserted mid-DATA of frame 0x99 -> outputs return to reset values; a following frame 0x66 is read as 0x66.
